dout_uart_tx: RTL and testbench



---
 rtl/dout_uart_tx.sv | 126 ++++++++++++
 tb/tb_dout_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dout_uart_tx.sv
// DOUT serial output stage: byte FIFO feeding an 8N1 LSB-first UART transmitter.
// A write that finds the FIFO full with no pop that cycle is dropped and pulses overflow.
module dout_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_strobe,
    input  logic [7:0]                      wr_data,
    output logic                            tx,
    output logic                            tx_busy,
    output logic                            fifo_empty,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          pop, push, baud_tc, tx_nxt;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_count = count;
    assign tx_busy    = (state != IDLE);
    assign baud_tc    = (baud_cnt == BAUD_LAST);
    // A full FIFO still accepts a write when the transmitter frees a slot on the same edge
    assign push       = wr_strobe && (!fifo_full || pop);

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_tc) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    bit_nxt   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    baud_nxt = '0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pop) shift_nxt = mem[rd_ptr];
        // Line level is decided from the next state so tx comes straight off a flop
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            overflow <= wr_strobe && fifo_full && !pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_dout_uart_tx.sv
// Bench for dout_uart_tx: queue-and-timeline reference model of FIFO occupancy and line level.
module tb_dout_uart_tx;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
    localparam int FRAME = 10 * C;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_strobe = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          tx, tx_busy, fifo_empty, fifo_full, overflow;
    logic [CW-1:0] fifo_count;

    dout_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .tx(tx), .tx_busy(tx_busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    wire [CW+4:0] obs = {tx, tx_busy, fifo_empty, fifo_full, fifo_count, overflow};

    // Reference: queue of accepted bytes, the edge at which the line next becomes free,
    // and the byte of the frame currently on the line.
    logic [7:0]   mq[$];
    logic [7:0]   cur = '0;
    int           e = 0;
    int           free_edge = 0;
    int           vec = 0;
    int           miss = 0;
    logic [CW+4:0] expv;

    task automatic tick(input logic r, input logic w, input logic [7:0] d);
        logic pop_now, pushed, etx, ebusy, eovf;
        int off, bi, cnt;
        reset = r; wr_strobe = w; wr_data = d;
        @(posedge clk);
        e++;
        eovf = 1'b0;
        if (r) begin
            mq.delete();
            free_edge = e;
        end else begin
            pop_now = (mq.size() > 0) && (e >= free_edge);
            if (pop_now) begin
                cur = mq.pop_front();
                free_edge = e + FRAME;
            end
            pushed = w && (mq.size() < D);
            if (pushed) mq.push_back(d);
            eovf = w && !pushed;
        end
        if (e < free_edge) begin
            off = e - (free_edge - FRAME);
            bi  = off / C;
            etx = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : cur[bi-1];
            ebusy = 1'b1;
        end else begin
            etx = 1'b1;
            ebusy = 1'b0;
        end
        cnt  = mq.size();
        expv = {etx, ebusy, cnt == 0, cnt == D, CW'(cnt), eovf};
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 8'h00);
            vec++;
            if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, CW'(0), 1'b0}) begin
                miss++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", e, obs, {1'b1, 1'b0, 1'b1, 1'b0, CW'(0), 1'b0});
            end
        end
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_single_byte();
        logic [9:0] pat;
        pat = 10'b11_0100_1010;
        tick(1'b0, 1'b1, 8'hA5);
        vec++;
        if (obs !== expv) begin miss++; $display("FAIL single_wr cyc=%0d got=%b exp=%b", e, obs, expv); end
        for (int i = 1; i <= FRAME + 2; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            vec++;
            if (obs !== expv) begin miss++; $display("FAIL single_model cyc=%0d got=%b exp=%b", e, obs, expv); end
            if (i <= FRAME) begin
                vec++;
                if (tx !== pat[(i-1)/C] || tx_busy !== 1'b1) begin
                    miss++;
                    $display("FAIL single_line i=%0d got tx=%b busy=%b exp tx=%b busy=1", i, tx, tx_busy, pat[(i-1)/C]);
                end
            end
        end
        vec++;
        if (tx_busy !== 1'b0 || fifo_count !== '0) begin
            miss++; $display("FAIL single_end got busy=%b cnt=%0d exp busy=0 cnt=0", tx_busy, fifo_count);
        end
    endtask

    task automatic test_fill_overflow();
        int pulses = 0;
        int seen_full = 0;
        for (int i = 1; i <= 6 + 5 * FRAME + 4; i++) begin
            tick(1'b0, i <= 6, 8'(i));
            vec++;
            if (obs !== expv) begin miss++; $display("FAIL fill cyc=%0d got=%b exp=%b", e, obs, expv); end
            if (overflow === 1'b1) pulses++;
            if (fifo_full === 1'b1) seen_full++;
        end
        vec++;
        if (pulses != 1 || seen_full == 0) begin
            miss++; $display("FAIL fill_ovf got pulses=%0d full_cycles=%0d exp pulses=1 full_cycles>0", pulses, seen_full);
        end
    endtask

    task automatic test_push_pop();
        int guard = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 8'($urandom));
            vec++;
            if (obs !== expv) begin miss++; $display("FAIL pp_fill cyc=%0d got=%b exp=%b", e, obs, expv); end
        end
        while ((e + 1) != free_edge && guard < 2 * FRAME) begin
            tick(1'b0, 1'b0, 8'h00);
            guard++;
        end
        tick(1'b0, 1'b1, 8'h3C);
        vec++;
        if (overflow !== 1'b0 || fifo_count !== CW'(D) || obs !== expv) begin
            miss++; $display("FAIL push_pop got=%b ovf=%b cnt=%0d exp=%b ovf=0 cnt=%0d", obs, overflow, fifo_count, expv, D);
        end
        for (int i = 0; i < 5 * FRAME + 4; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            vec++;
            if (obs !== expv) begin miss++; $display("FAIL pp_drain cyc=%0d got=%b exp=%b", e, obs, expv); end
        end
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b0, 1'b1, 8'hC3);
        tick(1'b0, 1'b1, 8'h5A);
        repeat (16) tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 8'hFF);
        vec++;
        if (tx !== 1'b1 || fifo_empty !== 1'b1 || tx_busy !== 1'b0 || obs !== expv) begin
            miss++; $display("FAIL rst_mid got tx=%b empty=%b busy=%b exp tx=1 empty=1 busy=0", tx, fifo_empty, tx_busy);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            vec++;
            if (obs !== expv || tx !== 1'b1) begin miss++; $display("FAIL rst_idle cyc=%0d got=%b exp=%b", e, obs, expv); end
        end
    endtask

    task automatic test_wrap();
        int maxc = 0;
        for (int b = 0; b < 9; b++) begin
            int gap = $urandom_range(36, 44);
            for (int i = 0; i < gap; i++) begin
                tick(1'b0, i == 0, 8'($urandom));
                vec++;
                if (obs !== expv) begin miss++; $display("FAIL wrap cyc=%0d got=%b exp=%b", e, obs, expv); end
                if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            end
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            vec++;
            if (obs !== expv) begin miss++; $display("FAIL wrap_drain cyc=%0d got=%b exp=%b", e, obs, expv); end
        end
        vec++;
        if (fifo_count !== '0 || maxc > 2) begin
            miss++; $display("FAIL wrap_end got cnt=%0d max=%0d exp cnt=0 max<=2", fifo_count, maxc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            logic w;
            w = (i < 1300) && ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 4 : 40));
            tick(1'b0, w, 8'($urandom));
            vec++;
            if (obs !== expv) begin miss++; $display("FAIL random cyc=%0d got=%b exp=%b", e, obs, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_push_pop();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
